pipe_skid_reg: RTL and testbench

- Parametrised pipeline register stage with valid/ready handshake and a 2-entry skid buffer. It is the successor of the fixed 32-bit clearable flop between CPU pipeline stages.
- Adds configurable width, a reset value, back-pressure (stall) without a combinational ready path, and a synchronous flush that inserts bubbles.
- Sits between any two pipeline stages, e.g. IF/ID and ID/EX.

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/pipe_dffe.sv | 31 +++
 rtl/pipe_skid_reg.sv | 86 ++++++++
 tb/tb_pipe_skid_reg.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline register: state encoding,
// default width, and the control transition function.
package pipe_pkg;

    localparam int unsigned PIPE_W = 32;

    // Encoded as {skid_valid, main_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } pipe_state_e;

    // Flush dominates any same-cycle accept or take.
    function automatic pipe_state_e pipe_next(input pipe_state_e st,
                                              input logic        acc,
                                              input logic        take,
                                              input logic        flush);
        pipe_state_e nxt;
        nxt = st;
        if (flush) begin
            nxt = ST_EMPTY;
        end else begin
            case (st)
                ST_EMPTY: if (acc) nxt = ST_ONE;
                ST_ONE: begin
                    if (acc && !take)      nxt = ST_FULL;
                    else if (!acc && take) nxt = ST_EMPTY;
                end
                ST_FULL:  if (take) nxt = ST_ONE;
                default:  nxt = ST_EMPTY;
            endcase
        end
        return nxt;
    endfunction

    function automatic logic [1:0] pipe_count(input pipe_state_e st);
        return 2'(st[0]) + 2'(st[1]);
    endfunction

endpackage

// File: rtl/pipe_dffe.sv
// Payload register: async active-low clear to RESET_VAL, synchronous clear
// (higher priority) and synchronous load-enable.
module pipe_dffe
    import pipe_pkg::*;
#(
    parameter int unsigned          WIDTH     = PIPE_W,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            data_q <= RESET_VAL;
        end else if (clr_i) begin
            data_q <= RESET_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with valid/ready handshake and a 2-entry skid buffer;
// in_ready comes straight from a flop so upstream never sees out_ready combinationally.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = PIPE_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    pipe_state_e      state_q, state_d;
    logic             in_ready_q;
    logic [1:0]       count_q;
    logic             acc, take;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    // Handshake decode and payload steering.
    always_comb begin
        acc     = in_valid & in_ready_q;
        take    = state_q[0] & out_ready;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        case (state_q)
            ST_EMPTY: main_en = acc;
            ST_ONE: begin
                main_en = acc & take;
                skid_en = acc & ~take;
            end
            ST_FULL: begin
                main_en = take;
                main_d  = skid_q;
            end
            default: ;
        endcase
        state_d = pipe_next(state_q, acc, take, flush);
    end

    // Ready and occupancy are registered from the next state.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
            count_q    <= pipe_count(state_d);
        end
    end

    pipe_dffe #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk   (clk),
        .clrn  (clrn),
        .clr_i (flush),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_dffe #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk   (clk),
        .clrn  (clrn),
        .clr_i (flush),
        .en_i  (skid_en),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = state_q[0];
    assign out_data  = main_q;
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table on a 64-bit instance, reset and
// randomised traffic on 64-bit and 8-bit instances, each with an order scoreboard.
module tb_pipe_skid_reg;

    localparam logic [63:0] RV_A = 64'hFFFF_0000_1234_5678;
    localparam logic [7:0]  RV_B = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn;
    logic        flush_a, iv_a, ir_a, ov_a, or_a;
    logic [63:0] id_a, od_a;
    logic [1:0]  cnt_a;
    logic        flush_b, iv_b, ir_b, ov_b, or_b;
    logic [7:0]  id_b, od_b;
    logic [1:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(.WIDTH(64), .RESET_VAL(RV_A)) u_dut_a (
        .clk(clk), .clrn(clrn), .flush(flush_a), .in_valid(iv_a), .in_data(id_a),
        .in_ready(ir_a), .out_valid(ov_a), .out_data(od_a), .out_ready(or_a), .count(cnt_a)
    );

    pipe_skid_reg #(.WIDTH(8), .RESET_VAL(RV_B)) u_dut_b (
        .clk(clk), .clrn(clrn), .flush(flush_b), .in_valid(iv_b), .in_data(id_b),
        .in_ready(ir_b), .out_valid(ov_b), .out_data(od_b), .out_ready(or_b), .count(cnt_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // Scoreboard and invariant monitor for instance A.
    logic [63:0] q_a[$];
    logic        hold_a;
    logic [63:0] hold_d_a;
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q_a.delete();
            hold_a = 1'b0;
        end else begin
            chk("a_illegal_state", 64'(!ir_a && !ov_a), 64'd0);
            chk("a_count", 64'(cnt_a), 64'(ov_a) + 64'(!ir_a));
            if (hold_a) begin
                chk("a_stable_valid", 64'(ov_a), 64'd1);
                chk("a_stable_data", od_a, hold_d_a);
            end
            hold_a   = ov_a && !or_a && !flush_a;
            hold_d_a = od_a;
            if (ov_a && or_a) begin
                if (q_a.size() == 0) chk("a_sb_underflow", 64'd0, 64'd1);
                else chk("a_sb_data", od_a, q_a.pop_front());
            end
            if (flush_a) q_a.delete();
            else if (iv_a && ir_a) q_a.push_back(id_a);
        end
    end

    // Scoreboard and invariant monitor for instance B.
    logic [7:0] q_b[$];
    logic       hold_b;
    logic [7:0] hold_d_b;
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q_b.delete();
            hold_b = 1'b0;
        end else begin
            chk("b_illegal_state", 64'(!ir_b && !ov_b), 64'd0);
            chk("b_count", 64'(cnt_b), 64'(ov_b) + 64'(!ir_b));
            if (hold_b) begin
                chk("b_stable_valid", 64'(ov_b), 64'd1);
                chk("b_stable_data", 64'(od_b), 64'(hold_d_b));
            end
            hold_b   = ov_b && !or_b && !flush_b;
            hold_d_b = od_b;
            if (ov_b && or_b) begin
                if (q_b.size() == 0) chk("b_sb_underflow", 64'd0, 64'd1);
                else chk("b_sb_data", 64'(od_b), 64'(q_b.pop_front()));
            end
            if (flush_b) q_b.delete();
            else if (iv_b && ir_b) q_b.push_back(id_b);
        end
    end

    typedef struct {
        logic        iv;
        logic [63:0] id;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic [1:0]  e_cnt;
        logic [63:0] e_od;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [63:0] id, input logic ordy, input logic fl,
                       input logic e_ov, input logic e_ir, input logic [1:0] e_cnt,
                       input logic [63:0] e_od);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_cnt = e_cnt; v.e_od = e_od;
        vecs.push_back(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_a(input string nm);
        chk({nm, "_ov"}, 64'(ov_a), 64'd0);
        chk({nm, "_ir"}, 64'(ir_a), 64'd1);
        chk({nm, "_cnt"}, 64'(cnt_a), 64'd0);
        chk({nm, "_od"}, od_a, RV_A);
    endtask

    initial begin
        int thr_a, thr_b;
        clrn = 1'b0;
        flush_a = 1'b0; iv_a = 1'b0; id_a = '0; or_a = 1'b0;
        flush_b = 1'b0; iv_b = 1'b0; id_b = '0; or_b = 1'b0;
        cyc();
        cyc();
        chk_idle_a("reset");
        chk("reset_b_od", 64'(od_b), 64'(RV_B));
        clrn = 1'b1;

        // Streaming at full rate.
        for (int k = 1; k <= 5; k++) add(1'b1, 64'(k), 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'(k));
        add(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 64'h5);
        // Stall into skid, then release.
        add(1'b1, 64'hA, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'hA);
        add(1'b1, 64'hB, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 64'hA);
        add(1'b1, 64'hC, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 64'hA);
        add(1'b1, 64'hC, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 64'hA);
        add(1'b1, 64'hC, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'hB);
        add(1'b1, 64'hC, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'hC);
        add(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 64'hC);
        // Simultaneous accept and take in ONE.
        add(1'b1, 64'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 64'h11);
        add(1'b1, 64'h22, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h22);
        add(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 64'h22);
        // Flush in FULL with a competing input.
        add(1'b1, 64'h33, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 64'h22);
        add(1'b1, 64'hDEAD, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, RV_A);
        add(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, RV_A);
        // Flush in ONE with same-cycle take and accept, then flush in EMPTY.
        add(1'b1, 64'h44, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h44);
        add(1'b1, 64'h55, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, RV_A);
        add(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, RV_A);
        add(1'b1, 64'h66, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 64'h66);

        foreach (vecs[i]) begin
            iv_a = vecs[i].iv; id_a = vecs[i].id; or_a = vecs[i].ordy; flush_a = vecs[i].fl;
            cyc();
            chk($sformatf("vec%0d_ov", i), 64'(ov_a), 64'(vecs[i].e_ov));
            chk($sformatf("vec%0d_ir", i), 64'(ir_a), 64'(vecs[i].e_ir));
            chk($sformatf("vec%0d_cnt", i), 64'(cnt_a), 64'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_od", i), od_a, vecs[i].e_od);
        end

        // Asynchronous reset while FULL: outputs return before the next edge.
        iv_a = 1'b1; id_a = 64'h77; or_a = 1'b0; flush_a = 1'b0;
        cyc();
        chk("pre_reset_cnt", 64'(cnt_a), 64'd2);
        clrn = 1'b0;
        iv_a = 1'b0;
        #1;
        chk_idle_a("async_reset");
        cyc();
        cyc();
        chk_idle_a("held_reset");
        clrn = 1'b1;
        cyc();
        chk("post_reset_ov", 64'(ov_a), 64'd0);

        // Randomised traffic on both widths with varying back-pressure.
        thr_a = 50;
        thr_b = 50;
        for (int n = 0; n < 10000; n++) begin
            if (n % 1000 == 0) begin
                thr_a = int'($urandom_range(10, 95));
                thr_b = int'($urandom_range(10, 95));
            end
            iv_a    = ($urandom_range(0, 3) != 0);
            id_a    = {$urandom, $urandom};
            or_a    = (int'($urandom_range(0, 99)) < thr_a);
            flush_a = ($urandom_range(0, 199) == 0);
            iv_b    = ($urandom_range(0, 3) != 0);
            id_b    = 8'($urandom);
            or_b    = (int'($urandom_range(0, 99)) < thr_b);
            flush_b = ($urandom_range(0, 199) == 0);
            cyc();
        end

        // Drain and confirm nothing was lost.
        iv_a = 1'b0; or_a = 1'b1; flush_a = 1'b0;
        iv_b = 1'b0; or_b = 1'b1; flush_b = 1'b0;
        for (int n = 0; n < 5; n++) cyc();
        chk("drain_a_left", 64'(q_a.size()), 64'd0);
        chk("drain_b_left", 64'(q_b.size()), 64'd0);
        chk("drain_a_ov", 64'(ov_a), 64'd0);
        chk("drain_b_ov", 64'(ov_b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
